// File: rtl/muxn_pipe.sv
`default_nettype none
// ============================================================================
// Module   : muxn_pipe
// Brief    : N-input WIDTH-bit selector with per-channel valid/ready and a
//            2-entry registered output buffer. Only the channel named by sel_i
//            is drained. in_ready_o depends on sel_i and the registered
//            occupancy only, so there is no combinational path from
//            out_ready_i to any in_ready_o.
// Options  : define MUXN_PIPE_TAG_EN to add out_chan_o. This output carries the
//            index of the channel that each buffered beat was accepted from.
// Revision : 1.0  initial release
// ============================================================================
module muxn_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data_i,
    input  logic [N-1:0]         in_valid_i,
    output logic [N-1:0]         in_ready_o,
    input  logic [SELW-1:0]      sel_i,
    output logic                 sel_err_o,
`ifdef MUXN_PIPE_TAG_EN
    output logic [SELW-1:0]      out_chan_o,
`endif
    output logic [WIDTH-1:0]     out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);

    // Buffer occupancy: 0, 1 or 2 beats
    logic [1:0]       count_q, count_d;
    // head_q is the oldest beat and drives out_data_o directly
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
`ifdef MUXN_PIPE_TAG_EN
    logic [SELW-1:0]  head_tag_q, head_tag_d;
    logic [SELW-1:0]  tail_tag_q, tail_tag_d;
`endif

    logic [WIDTH-1:0] w_sel_data;
    logic             w_space;
    logic             w_push;
    logic             w_pop;

    assign w_space     = (count_q != 2'd2);
    assign sel_err_o   = (int'(sel_i) >= N);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
`ifdef MUXN_PIPE_TAG_EN
    assign out_chan_o  = head_tag_q;
`endif

    // Ready goes only to the selected channel, and only while there is room.
    // An out-of-range select matches no channel.
    always_comb begin
        in_ready_o = '0;
        for (int i = 0; i < N; i++) begin
            in_ready_o[i] = (int'(sel_i) == i) && w_space && rst_n;
        end
    end

    // Data mux for the selected channel. Unselected data is never used.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(sel_i) == i) begin
                w_sel_data = in_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    // At most one channel can be ready, so this OR is a single handshake
    assign w_push = |(in_valid_i & in_ready_o);
    assign w_pop  = out_valid_o && out_ready_i;

    // Next-state logic for the buffer. Push and pop together only happen at
    // count 1, because at count 0 there is nothing to pop and at count 2
    // nothing can be pushed. In that case the new beat replaces the head.
    always_comb begin
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
`ifdef MUXN_PIPE_TAG_EN
        head_tag_d = head_tag_q;
        tail_tag_d = tail_tag_q;
`endif
        case ({w_push, w_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d     = w_sel_data;
`ifdef MUXN_PIPE_TAG_EN
                    head_tag_d = sel_i;
`endif
                end else begin
                    tail_d     = w_sel_data;
`ifdef MUXN_PIPE_TAG_EN
                    tail_tag_d = sel_i;
`endif
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                // Promote the tail. If the buffer is emptied, head is stale
                // but hidden by out_valid_o.
                head_d     = tail_q;
`ifdef MUXN_PIPE_TAG_EN
                head_tag_d = tail_tag_q;
`endif
                count_d    = count_q - 2'd1;
            end
            2'b11: begin
                head_d     = w_sel_data;
`ifdef MUXN_PIPE_TAG_EN
                head_tag_d = sel_i;
`endif
            end
            default: begin
            end
        endcase
    end

    // Buffer registers. Reset discards any buffered beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
`ifdef MUXN_PIPE_TAG_EN
            head_tag_q <= '0;
            tail_tag_q <= '0;
`endif
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
`ifdef MUXN_PIPE_TAG_EN
            head_tag_q <= head_tag_d;
            tail_tag_q <= tail_tag_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muxn_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_muxn_pipe
// Brief    : Self-checking bench for muxn_pipe. It uses a queue scoreboard for
//            the N=4 instance and directed checks for an N=3 instance that
//            exercises an out-of-range select.
// Revision : 1.0  initial release
// ============================================================================
module tb_muxn_pipe;

    logic         clk;
    logic         rst_n;

    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [1:0]   sel;
    logic         sel_err;
    logic [1:0]   out_chan;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;

    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [1:0]   sel3;
    logic         sel_err3;
    logic [1:0]   out_chan3;
    logic [31:0]  out_data3;
    logic         out_valid3;
    logic         out_ready3;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard entries are {channel, data}
    logic [33:0] sbq[$];

    muxn_pipe #(.WIDTH(32), .N(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .sel_i      (sel),
        .sel_err_o  (sel_err),
`ifdef MUXN_PIPE_TAG_EN
        .out_chan_o (out_chan),
`endif
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready)
    );

    muxn_pipe #(.WIDTH(32), .N(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data_i  (in_data3),
        .in_valid_i (in_valid3),
        .in_ready_o (in_ready3),
        .sel_i      (sel3),
        .sel_err_o  (sel_err3),
`ifdef MUXN_PIPE_TAG_EN
        .out_chan_o (out_chan3),
`endif
        .out_data_o (out_data3),
        .out_valid_o(out_valid3),
        .out_ready_i(out_ready3)
    );

`ifndef MUXN_PIPE_TAG_EN
    assign out_chan  = 2'd0;
    assign out_chan3 = 2'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected in_ready for the N=4 instance, derived from the model occupancy
    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        r = '0;
        if (rst_n && sbq.size() < 2) r[sel] = 1'b1;
        return r;
    endfunction

    // Advance the reference model at a rising edge using the bench-driven inputs
    task automatic model_step();
        logic push, pop;
        if (!rst_n) begin
            sbq.delete();
            return;
        end
        pop  = (sbq.size() != 0) && out_ready;
        push = in_valid[sel] && (sbq.size() < 2);
        if (pop) void'(sbq.pop_front());
        if (push) sbq.push_back({sel, in_data[sel*32 +: 32]});
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
        in_data = '0; in_data[32 +: 32] = 32'hBBBBBBBB;
        repeat (2) begin @(posedge clk); model_step(); end
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset out_data: got %h expected 0", out_data); end
        n_tests++; if (in_ready !== 4'b0) begin n_fail++; $display("FAIL reset in_ready: got %b expected 0000", in_ready); end
        n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset sel_err: got %b expected 0", sel_err); end
        n_tests++; if (out_valid3 !== 1'b0 || in_ready3 !== 3'b0) begin n_fail++; $display("FAIL reset dut3: got v=%b r=%b expected 0/000", out_valid3, in_ready3); end
`ifdef MUXN_PIPE_TAG_EN
        n_tests++; if (out_chan !== 2'd0) begin n_fail++; $display("FAIL reset out_chan: got %0d expected 0", out_chan); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 6) ? 4'b0010 : 4'b0000;
            in_data[32 +: 32] = 32'hBBBBBBBB + c;
            @(negedge clk);
            n_tests++; if (out_valid !== (sbq.size() != 0)) begin n_fail++; $display("FAIL basic out_valid c%0d: got %b expected %b", c, out_valid, sbq.size() != 0); end
            if (sbq.size() != 0) begin
                n_tests++; if (out_data !== sbq[0][31:0]) begin n_fail++; $display("FAIL basic out_data c%0d: got %h expected %h", c, out_data, sbq[0][31:0]); end
`ifdef MUXN_PIPE_TAG_EN
                n_tests++; if (out_chan !== sbq[0][33:32]) begin n_fail++; $display("FAIL basic out_chan c%0d: got %0d expected %0d", c, out_chan, sbq[0][33:32]); end
`endif
            end
            n_tests++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL basic in_ready c%0d: got %b expected %b", c, in_ready, exp_ready()); end
            @(posedge clk); model_step(); #1;
        end
    endtask

    task automatic test_backpressure();
        sel = 2'd2;
        for (int c = 0; c < 8; c++) begin
            out_ready = (c >= 4);
            in_valid  = (c < 4) ? 4'b0100 : 4'b0000;
            in_data[64 +: 32] = (c == 0) ? 32'h11111111 : (c == 1) ? 32'h22222222 : 32'h33333333;
            @(negedge clk);
            n_tests++; if (out_valid !== (sbq.size() != 0)) begin n_fail++; $display("FAIL bp out_valid c%0d: got %b expected %b", c, out_valid, sbq.size() != 0); end
            if (sbq.size() != 0) begin
                n_tests++; if (out_data !== sbq[0][31:0]) begin n_fail++; $display("FAIL bp out_data c%0d: got %h expected %h", c, out_data, sbq[0][31:0]); end
`ifdef MUXN_PIPE_TAG_EN
                n_tests++; if (out_chan !== sbq[0][33:32]) begin n_fail++; $display("FAIL bp out_chan c%0d: got %0d expected %0d", c, out_chan, sbq[0][33:32]); end
`endif
            end
            n_tests++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL bp in_ready c%0d: got %b expected %b", c, in_ready, exp_ready()); end
            @(posedge clk); model_step(); #1;
        end
    endtask

    task automatic test_select_switch();
        for (int c = 0; c < 8; c++) begin
            sel       = (c == 0) ? 2'd0 : 2'd3;
            out_ready = (c >= 3);
            in_valid  = (c == 1) ? 4'b1001 : (c < 6) ? 4'b0001 : 4'b0000;
            in_data[0 +: 32]  = (c == 0) ? 32'hAAAAAAAA : 32'hDEADBEEF;
            in_data[96 +: 32] = 32'h12345678;
            @(negedge clk);
            n_tests++; if (out_valid !== (sbq.size() != 0)) begin n_fail++; $display("FAIL switch out_valid c%0d: got %b expected %b", c, out_valid, sbq.size() != 0); end
            if (sbq.size() != 0) begin
                n_tests++; if (out_data !== sbq[0][31:0]) begin n_fail++; $display("FAIL switch out_data c%0d: got %h expected %h", c, out_data, sbq[0][31:0]); end
`ifdef MUXN_PIPE_TAG_EN
                n_tests++; if (out_chan !== sbq[0][33:32]) begin n_fail++; $display("FAIL switch out_chan c%0d: got %0d expected %0d", c, out_chan, sbq[0][33:32]); end
`endif
            end
            n_tests++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL switch in_ready c%0d: got %b expected %b", c, in_ready, exp_ready()); end
            @(posedge clk); model_step(); #1;
        end
    endtask

    task automatic test_back_to_back();
        sel = 2'd0; out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 10) ? 4'b0001 : 4'b0000;
            in_data[0 +: 32] = c;
            @(negedge clk);
            n_tests++; if (out_valid !== (sbq.size() != 0)) begin n_fail++; $display("FAIL b2b out_valid c%0d: got %b expected %b", c, out_valid, sbq.size() != 0); end
            if (sbq.size() != 0) begin
                n_tests++; if (out_data !== sbq[0][31:0]) begin n_fail++; $display("FAIL b2b out_data c%0d: got %h expected %h", c, out_data, sbq[0][31:0]); end
            end
            n_tests++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL b2b in_ready c%0d: got %b expected %b", c, in_ready, exp_ready()); end
            @(posedge clk); model_step(); #1;
        end
    endtask

    task automatic test_mid_reset();
        sel = 2'd1;
        for (int c = 0; c < 6; c++) begin
            rst_n     = (c != 2);
            out_ready = (c >= 3);
            in_valid  = (c < 3) ? 4'b0010 : 4'b0000;
            in_data[32 +: 32] = (c == 0) ? 32'h55555555 : 32'h66666666;
            @(negedge clk);
            n_tests++; if (out_valid !== (sbq.size() != 0)) begin n_fail++; $display("FAIL mrst out_valid c%0d: got %b expected %b", c, out_valid, sbq.size() != 0); end
            if (sbq.size() != 0) begin
                n_tests++; if (out_data !== sbq[0][31:0]) begin n_fail++; $display("FAIL mrst out_data c%0d: got %h expected %h", c, out_data, sbq[0][31:0]); end
            end
            if (c == 3) begin
                n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL mrst cleared out_data: got %h expected 0", out_data); end
            end
            n_tests++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL mrst in_ready c%0d: got %b expected %b", c, in_ready, exp_ready()); end
            @(posedge clk); model_step(); #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_out_of_range();
        sel3 = 2'd0; in_valid3 = 3'b001; out_ready3 = 1'b0;
        in_data3 = {32'h33333333, 32'h22222222, 32'hCAFE0001};
        @(negedge clk);
        n_tests++; if (sel_err3 !== 1'b0 || in_ready3 !== 3'b001) begin n_fail++; $display("FAIL oor pre: got err=%b r=%b expected 0/001", sel_err3, in_ready3); end
        @(posedge clk); #1;
        sel3 = 2'd3; in_valid3 = 3'b111;
        in_data3 = {32'h99999999, 32'h88888888, 32'h77777777};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++; if (sel_err3 !== 1'b1) begin n_fail++; $display("FAIL oor sel_err c%0d: got %b expected 1", c, sel_err3); end
            n_tests++; if (in_ready3 !== 3'b000) begin n_fail++; $display("FAIL oor in_ready c%0d: got %b expected 000", c, in_ready3); end
            n_tests++; if (out_valid3 !== 1'b1 || out_data3 !== 32'hCAFE0001) begin n_fail++; $display("FAIL oor hold c%0d: got v=%b d=%h expected 1/cafe0001", c, out_valid3, out_data3); end
`ifdef MUXN_PIPE_TAG_EN
            n_tests++; if (out_chan3 !== 2'd0) begin n_fail++; $display("FAIL oor out_chan c%0d: got %0d expected 0", c, out_chan3); end
`endif
            @(posedge clk); #1;
        end
        out_ready3 = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++; if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL oor drain c%0d: got %b expected 0", c, out_valid3); end
            @(posedge clk); #1;
        end
        in_valid3 = 3'b000; sel3 = 2'd0;
    endtask

    initial begin
        rst_n = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        sel3 = '0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_select_switch();
        test_back_to_back();
        test_mid_reset();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
